pair_grid_sequencer: RTL and testbench
======================================

Name: pair_grid_sequencer

Overview:
- Serial evaluator for the 12-input AND/NOR pair-grid function. The function has three row products and three column products, crossed into a 3x3 NOR grid, grouped ORs and a final NAND/OR combine.
- A single shared AND-AND-NOR cell is time-multiplexed over the nine row/column pairs. The block accumulates the four group ORs and produces the output bit.
- Sits between an operand source and a result sink, with valid/ready handshakes on both sides.
- Serves as the sequenced (area-reduced) counterpart of the flat combinational netlist, for equivalence and synthesis experiments.

Parameters:
- EARLY_EXIT, 0, when 1, skip the remaining pairs once the result is forced to 1 (see Behaviour).
- NUM_PAIRS, 9, number of grid pairs evaluated. Fixed at 9; any other value is a parse-time error.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand vector valid
- in_ready  output  1  block can accept an operand vector
- in_vec  input  12  operands {a,b,c,d,e,f,g,h,i,j,k,l}; in_vec[11]=a, in_vec[0]=l
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts result
- out_o  output  1  function result
- out_early  output  1  result was produced by early exit
- busy  output  1  evaluation in progress

Behaviour:
- One clock; reset is synchronous and active-low: rst_n sampled low at a rising clk edge resets all state.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_o=0, out_early=0, busy=0, idx=0, group accumulators G16..G19=0.
- Reset mid-operation abandons the vector; no result is emitted.
- Row products: R0=a&b, R1=c&d, R2=e&f. Column products: C0=g&h, C1=i&j, C2=k&l.
- Pair index k = 3*r + c, where r is the row and c the column, for k = 0..8. The pair term is P[k] = ~(R[r] | C[c]).
- Groups (contiguous in k): G16 = P0|P1; G17 = P2|P3; G18 = P4|P5; G19 = P6|P7|P8.
- Result: out_o = ~(G17 & G19) | (G16 & G18).
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_vec into the operand register, clear G*, set idx=0, go to EVAL.
  - EVAL: in_ready=0, busy=1. Each cycle evaluates P[idx] on the shared cell and ORs it into its group.
    - At idx=8, go to RESULT.
    - If EARLY_EXIT=1 and idx=3 and the updated G17=0, go to RESULT with out_early=1. The result is then forced to 1.
    - Otherwise idx++.
  - RESULT: out_valid=1, out_o and out_early held stable, busy=0, in_ready=0. On out_valid&out_ready, go to IDLE next cycle and clear out_valid.
- Latency, with T0 the accept edge:
  - Full evaluation: out_valid rises at edge T0+9.
  - Early exit: out_valid rises at edge T0+4.
- Back-to-back: the earliest next accept is one cycle after result handshake; there is no overlap.
- Handshake rules:
  - in_vec is ignored except on the accept edge.
  - Changing in_vec during EVAL has no effect.
  - out_ready held low keeps RESULT indefinitely with stable outputs.
- No X propagation: the operand register and G* are always reset or loaded.

Decomposition:
- Shared package pair_grid_pkg:
  - state enum {IDLE, EVAL, RESULT}
  - NUM_ROWS=3, NUM_COLS=3
  - group-boundary constants: G16 end=1, G17 end=3, G18 end=5, G19 end=8
  - EARLY_IDX=3
  - index-to-(row,col) decode function
- One sub-module, pair_nor_cell: combinational, inputs (x0,x1,y0,y1), output ~((x0&x1)|(y0&y1)). It is instantiated once and driven by muxes on idx.

Test Plan:
- in_vec=12'h000, EARLY_EXIT=0 -> all P=1, G16..G19=1; out_o=1 at T0+9, out_early=0.
- in_vec=12'hC00 (a=b=1 only) -> G16=0, G17=G18=G19=1; out_o=0 at T0+9.
- in_vec=12'hFFF, EARLY_EXIT=1 -> G17=0 at idx3; out_o=1, out_early=1, out_valid at T0+4. Same vector with EARLY_EXIT=0 -> out_o=1 at T0+9.
- Result backpressure: out_ready=0 for 5 cycles after out_valid -> out_o/out_valid stable, in_ready=0, a new in_valid is not accepted; out_ready=1 -> IDLE next cycle.
- rst_n=0 at idx=4 with in_vec=12'hC00 -> next cycle in IDLE, in_ready=1, out_valid=0, no result emitted. A following accept of 12'h000 gives out_o=1 at T0+9.
- Random 12-bit sweep of all 4096 vectors against the flat reference function -> out_o matches. For EARLY_EXIT=1, out_early=1 exactly when G17=0.

Source files
------------

// File: rtl/pair_grid_pkg.sv
// -----------------------------------------------------------------------------
// pair_grid_pkg
// Shared types and constants for the sequenced 12-input AND/NOR pair-grid
// evaluator: FSM state encoding, grid dimensions, group boundaries in pair-index
// space and the pair-index to (row, column) decode.
// -----------------------------------------------------------------------------
package pair_grid_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    RESULT = 2'd2
  } state_e;

  localparam int NUM_ROWS = 3;
  localparam int NUM_COLS = 3;

  // Last pair index belonging to each group (groups are contiguous in k).
  localparam logic [3:0] G16_END = 4'd1;
  localparam logic [3:0] G17_END = 4'd3;
  localparam logic [3:0] G18_END = 4'd5;
  localparam logic [3:0] G19_END = 4'd8;

  // G17 is complete after this index, which is when early exit can decide.
  localparam logic [3:0] EARLY_IDX = G17_END;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } pair_rc_t;

  // k = NUM_COLS*row + col, tabulated to avoid a divider.
  function automatic pair_rc_t idx_to_rc(input logic [3:0] idx);
    pair_rc_t rc;
    case (idx)
      4'd0:    rc = '{row: 2'd0, col: 2'd0};
      4'd1:    rc = '{row: 2'd0, col: 2'd1};
      4'd2:    rc = '{row: 2'd0, col: 2'd2};
      4'd3:    rc = '{row: 2'd1, col: 2'd0};
      4'd4:    rc = '{row: 2'd1, col: 2'd1};
      4'd5:    rc = '{row: 2'd1, col: 2'd2};
      4'd6:    rc = '{row: 2'd2, col: 2'd0};
      4'd7:    rc = '{row: 2'd2, col: 2'd1};
      4'd8:    rc = '{row: 2'd2, col: 2'd2};
      default: rc = '{row: 2'd0, col: 2'd0};
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/pair_grid_if.sv
// -----------------------------------------------------------------------------
// pair_grid_if
// Operand/result handshake bundle for pair_grid_sequencer.
//   in_valid/in_ready/in_vec    : operand vector, source -> block
//   out_valid/out_ready/out_o   : result bit, block -> sink
//   out_early                   : result came from the early-exit path
//   busy                        : evaluation in progress
// master = operand source / result sink side, slave = the evaluator.
// -----------------------------------------------------------------------------
interface pair_grid_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic        out_o;
  logic        out_early;
  logic        busy;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_o, out_early, busy
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_o, out_early, busy
  );
endinterface

// File: rtl/pair_grid_sequencer_cell.sv
// -----------------------------------------------------------------------------
// pair_nor_cell
// Shared AND-AND-NOR cell: o_p = ~((i_x0 & i_x1) | (i_y0 & i_y1)).
//   i_x0/i_x1 : operand pair forming the row product
//   i_y0/i_y1 : operand pair forming the column product
//   o_p       : pair term
// -----------------------------------------------------------------------------
module pair_nor_cell (
  input  logic i_x0,
  input  logic i_x1,
  input  logic i_y0,
  input  logic i_y1,
  output logic o_p
);

  assign o_p = ~((i_x0 & i_x1) | (i_y0 & i_y1));

endmodule

// File: rtl/pair_grid_sequencer.sv
// -----------------------------------------------------------------------------
// pair_grid_sequencer
// Serial evaluator of the 12-input pair-grid function
//   out = ~(G17 & G19) | (G16 & G18), with P[3r+c] = ~(R[r] | C[c]).
// One pair_nor_cell is stepped over the nine pairs, one per cycle, and each
// pair term is ORed into its group accumulator.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : pair_grid_if.slave (operand in, result out, busy)
// -----------------------------------------------------------------------------
module pair_grid_sequencer
  import pair_grid_pkg::*;
#(
  parameter int EARLY_EXIT = 0,
  parameter int NUM_PAIRS  = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  pair_grid_if.slave     bus
);

  if (NUM_PAIRS != 9) begin : g_num_pairs_check
    $error("pair_grid_sequencer: NUM_PAIRS must be 9");
  end

  state_e      r_state;
  logic [11:0] r_vec;
  logic [3:0]  r_idx;
  logic        r_g16, r_g17, r_g18, r_g19;
  logic        r_in_ready, r_out_valid, r_out_o, r_out_early, r_busy;

  pair_rc_t    w_rc;
  logic        w_x0, w_x1, w_y0, w_y1, w_p;
  logic        w_g16_nxt, w_g17_nxt, w_g18_nxt, w_g19_nxt;
  logic        w_res, w_early_hit;

  assign w_rc = idx_to_rc(r_idx);

  // Route the current pair's row and column operands onto the shared cell.
  always_comb begin
    w_x0 = 1'b0;
    w_x1 = 1'b0;
    w_y0 = 1'b0;
    w_y1 = 1'b0;
    case (w_rc.row)
      2'd0:    begin w_x0 = r_vec[11]; w_x1 = r_vec[10]; end
      2'd1:    begin w_x0 = r_vec[9];  w_x1 = r_vec[8];  end
      2'd2:    begin w_x0 = r_vec[7];  w_x1 = r_vec[6];  end
      default: begin w_x0 = 1'b0;      w_x1 = 1'b0;      end
    endcase
    case (w_rc.col)
      2'd0:    begin w_y0 = r_vec[5]; w_y1 = r_vec[4]; end
      2'd1:    begin w_y0 = r_vec[3]; w_y1 = r_vec[2]; end
      2'd2:    begin w_y0 = r_vec[1]; w_y1 = r_vec[0]; end
      default: begin w_y0 = 1'b0;     w_y1 = 1'b0;     end
    endcase
  end

  pair_nor_cell u_cell (
    .i_x0 (w_x0),
    .i_x1 (w_x1),
    .i_y0 (w_y0),
    .i_y1 (w_y1),
    .o_p  (w_p)
  );

  // Accumulator values after ORing in this cycle's pair term.
  always_comb begin
    w_g16_nxt = r_g16;
    w_g17_nxt = r_g17;
    w_g18_nxt = r_g18;
    w_g19_nxt = r_g19;
    if (r_idx <= G16_END) begin
      w_g16_nxt = r_g16 | w_p;
    end else if (r_idx <= G17_END) begin
      w_g17_nxt = r_g17 | w_p;
    end else if (r_idx <= G18_END) begin
      w_g18_nxt = r_g18 | w_p;
    end else begin
      w_g19_nxt = r_g19 | w_p;
    end
  end

  // Result uses the updated groups so the last pair is included on the exit cycle.
  assign w_res       = ~(w_g17_nxt & w_g19_nxt) | (w_g16_nxt & w_g18_nxt);
  // G17 = 0 makes ~(G17 & G19) = 1, so the result is 1 whatever remains.
  assign w_early_hit = (EARLY_EXIT != 0) && (r_idx == EARLY_IDX) && !w_g17_nxt;

  // Control FSM, operand/accumulator registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_vec       <= 12'h000;
      r_idx       <= 4'd0;
      r_g16       <= 1'b0;
      r_g17       <= 1'b0;
      r_g18       <= 1'b0;
      r_g19       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_o     <= 1'b0;
      r_out_early <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_vec      <= bus.in_vec;
            r_idx      <= 4'd0;
            r_g16      <= 1'b0;
            r_g17      <= 1'b0;
            r_g18      <= 1'b0;
            r_g19      <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= EVAL;
          end
        end
        EVAL: begin
          r_g16 <= w_g16_nxt;
          r_g17 <= w_g17_nxt;
          r_g18 <= w_g18_nxt;
          r_g19 <= w_g19_nxt;
          if (w_early_hit) begin
            r_out_o     <= 1'b1;
            r_out_early <= 1'b1;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= RESULT;
          end else if (r_idx == 4'(NUM_PAIRS - 1)) begin
            r_out_o     <= w_res;
            r_out_early <= 1'b0;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= RESULT;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        RESULT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_o     = r_out_o;
  assign bus.out_early = r_out_early;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_pair_grid_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pair_grid_sequencer
// Runs one instance without early exit (dut0) and one with it (dut1) in
// lockstep on the same operand vectors, comparing against a flat reference of
// the pair-grid function.
// -----------------------------------------------------------------------------
module tb_pair_grid_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  pair_grid_if if0 ();
  pair_grid_if if1 ();

  pair_grid_sequencer #(.EARLY_EXIT(0), .NUM_PAIRS(9)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  pair_grid_sequencer #(.EARLY_EXIT(1), .NUM_PAIRS(9)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] vec;
    logic        o0;
    int          lat0;
    logic        o1;
    logic        e1;
    int          lat1;
  } vec_t;

  vec_t tbl [6];

  // Flat reference: returns {G16, G17, G18, G19}.
  function automatic logic [3:0] ref_groups(input logic [11:0] v);
    logic [2:0] r;
    logic [2:0] c;
    logic [8:0] p;
    for (int q = 0; q < 3; q++) begin
      r[q] = v[11 - 2*q] & v[10 - 2*q];
      c[q] = v[5 - 2*q] & v[4 - 2*q];
    end
    for (int k = 0; k < 9; k++) begin
      p[k] = ~(r[k / 3] | c[k % 3]);
    end
    return {|p[1:0], |p[3:2], |p[5:4], |p[8:6]};
  endfunction

  function automatic logic ref_out(input logic [11:0] v);
    logic [3:0] g;
    g = ref_groups(v);
    return ~(g[2] & g[0]) | (g[3] & g[1]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input logic [11:0] v, input logic exp_o0, input int exp_lat0,
                         input logic exp_o1, input logic exp_e1, input int exp_lat1,
                         input string tag);
    int   lat0;
    int   lat1;
    logic o0, e0, o1, e1;
    bit   d0, d1;
    lat0 = -1; lat1 = -1;
    o0 = 1'b0; e0 = 1'b0; o1 = 1'b0; e1 = 1'b0;
    d0 = 1'b0; d1 = 1'b0;
    @(negedge clk);
    chk({tag, " in_ready0 idle"}, int'(if0.in_ready), 1);
    chk({tag, " in_ready1 idle"}, int'(if1.in_ready), 1);
    if0.in_valid = 1'b1; if1.in_valid = 1'b1;
    if0.in_vec = v;      if1.in_vec = v;
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0; if1.in_valid = 1'b0;
    for (int n = 1; n <= 20 && !(d0 && d1); n++) begin
      // Operand changes after the accept edge must not matter.
      if0.in_vec = 12'($urandom); if1.in_vec = 12'($urandom);
      @(posedge clk);
      #1;
      if (!d0) begin
        if (if0.out_valid) begin
          d0 = 1'b1; lat0 = n; o0 = if0.out_o; e0 = if0.out_early;
          chk({tag, " busy0 at result"}, int'(if0.busy), 0);
          chk({tag, " in_ready0 at result"}, int'(if0.in_ready), 0);
        end else begin
          chk({tag, " busy0 in eval"}, int'(if0.busy), 1);
        end
      end
      if (!d1) begin
        if (if1.out_valid) begin
          d1 = 1'b1; lat1 = n; o1 = if1.out_o; e1 = if1.out_early;
          chk({tag, " busy1 at result"}, int'(if1.busy), 0);
        end else begin
          chk({tag, " busy1 in eval"}, int'(if1.busy), 1);
          chk({tag, " in_ready1 in eval"}, int'(if1.in_ready), 0);
        end
      end
    end
    chk({tag, " latency0"}, lat0, exp_lat0);
    chk({tag, " out_o0"}, int'(o0), int'(exp_o0));
    chk({tag, " out_early0"}, int'(e0), 0);
    chk({tag, " latency1"}, lat1, exp_lat1);
    chk({tag, " out_o1"}, int'(o1), int'(exp_o1));
    chk({tag, " out_early1"}, int'(e1), int'(exp_e1));
    // Let dut0's result handshake complete.
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] v;
    logic [3:0]  g;
    logic        seen;
    int unsigned base, mult;
    n_checks = 0;
    n_errors = 0;

    tbl[0] = '{vec: 12'h000, o0: 1'b1, lat0: 9, o1: 1'b1, e1: 1'b0, lat1: 9};
    tbl[1] = '{vec: 12'hC00, o0: 1'b0, lat0: 9, o1: 1'b0, e1: 1'b0, lat1: 9};
    tbl[2] = '{vec: 12'hFFF, o0: 1'b1, lat0: 9, o1: 1'b1, e1: 1'b1, lat1: 4};
    tbl[3] = '{vec: 12'h03F, o0: 1'b1, lat0: 9, o1: 1'b1, e1: 1'b1, lat1: 4};
    tbl[4] = '{vec: 12'h0F0, o0: 1'b1, lat0: 9, o1: 1'b1, e1: 1'b0, lat1: 9};
    tbl[5] = '{vec: 12'h30C, o0: 1'b0, lat0: 9, o1: 1'b0, e1: 1'b0, lat1: 9};

    rst_n = 1'b0;
    if0.in_valid = 1'b0; if1.in_valid = 1'b0;
    if0.in_vec = 12'h000; if1.in_vec = 12'h000;
    if0.out_ready = 1'b1; if1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset in_ready0", int'(if0.in_ready), 1);
    chk("reset out_valid0", int'(if0.out_valid), 0);
    chk("reset out_o0", int'(if0.out_o), 0);
    chk("reset out_early0", int'(if0.out_early), 0);
    chk("reset busy0", int'(if0.busy), 0);
    chk("reset in_ready1", int'(if1.in_ready), 1);
    chk("reset out_valid1", int'(if1.out_valid), 0);
    chk("reset busy1", int'(if1.busy), 0);

    // Directed vectors.
    for (int t = 0; t < 6; t++) begin
      run_vec(tbl[t].vec, tbl[t].o0, tbl[t].lat0, tbl[t].o1, tbl[t].e1, tbl[t].lat1,
              $sformatf("tbl%0d", t));
    end

    // Result backpressure: hold out_ready low, offer a new vector meanwhile.
    if0.out_ready = 1'b0; if1.out_ready = 1'b0;
    @(negedge clk);
    if0.in_valid = 1'b1; if1.in_valid = 1'b1;
    if0.in_vec = 12'hC00; if1.in_vec = 12'hC00;
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0; if1.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("bp out_valid0 at T0+9", int'(if0.out_valid), 1);
    chk("bp out_valid1 at T0+9", int'(if1.out_valid), 1);
    if0.in_valid = 1'b1; if1.in_valid = 1'b1;
    if0.in_vec = 12'h000; if1.in_vec = 12'h000;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      chk("bp out_valid0 held", int'(if0.out_valid), 1);
      chk("bp out_o0 held", int'(if0.out_o), 0);
      chk("bp in_ready0 low", int'(if0.in_ready), 0);
      chk("bp out_valid1 held", int'(if1.out_valid), 1);
      chk("bp out_o1 held", int'(if1.out_o), 0);
      chk("bp in_ready1 low", int'(if1.in_ready), 0);
    end
    if0.in_valid = 1'b0; if1.in_valid = 1'b0;
    if0.out_ready = 1'b1; if1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release out_valid0", int'(if0.out_valid), 0);
    chk("bp release in_ready0", int'(if0.in_ready), 1);
    chk("bp release out_valid1", int'(if1.out_valid), 0);
    chk("bp release in_ready1", int'(if1.in_ready), 1);

    // Reset in the middle of an evaluation (idx=4).
    @(negedge clk);
    if0.in_valid = 1'b1; if1.in_valid = 1'b1;
    if0.in_vec = 12'hC00; if1.in_vec = 12'hC00;
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0; if1.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid busy0 before reset", int'(if0.busy), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid-reset in_ready0", int'(if0.in_ready), 1);
    chk("mid-reset out_valid0", int'(if0.out_valid), 0);
    chk("mid-reset busy0", int'(if0.busy), 0);
    chk("mid-reset in_ready1", int'(if1.in_ready), 1);
    chk("mid-reset busy1", int'(if1.busy), 0);
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (if0.out_valid || if1.out_valid) seen = 1'b1;
    end
    chk("mid-reset no result emitted", int'(seen), 0);
    run_vec(12'h000, 1'b1, 9, 1'b1, 1'b0, 9, "post-reset");

    // Randomised permutation of all 4096 vectors against the flat reference.
    base = $urandom;
    mult = $urandom | 32'd1;
    for (int i = 0; i < 4096; i++) begin
      v = 12'(32'(i) * mult + base);
      g = ref_groups(v);
      run_vec(v, ref_out(v), 9, ref_out(v), ~g[2], (g[2] ? 9 : 4),
              $sformatf("sweep vec=%03h", v));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
